// File: rtl/cae_pers_multi_pkg.sv
// cae_pers_multi_pkg: shared FSM states, AEG/CSR maps and exception bits
// for the multi-engine PDES control front end.
package cae_pers_multi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_REDUCE = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam int AEG_RESULT = 0;
    localparam int AEG_CYCLES = 1;
    localparam int AEG_MASK   = 2;
    localparam int AEG_TMO    = 3;

    localparam logic [15:0] CSR_STATUS = 16'd0;
    localparam logic [15:0] CSR_RESULT = 16'd1;
    localparam logic [15:0] CSR_CYCLES = 16'd2;
    localparam logic [15:0] CSR_MASK   = 16'd3;

    localparam int EXC_OPCODE  = 0;
    localparam int EXC_IDX     = 1;
    localparam int EXC_RO      = 2;
    localparam int EXC_TIMEOUT = 3;

endpackage

// File: rtl/cae_pers_multi_ctl_gvt_min_tree.sv
// gvt_min_tree: combinational minimum over N W-bit values; entries whose
// valid bit is clear count as all-ones, so an empty set yields all-ones.
module gvt_min_tree #(
    parameter int N = 4,
    parameter int W = 14
) (
    input  logic [N*W-1:0] vals,
    input  logic [N-1:0]   vld,
    output logic [W-1:0]   min_val
);

    always_comb begin
        min_val = '1;
        for (int i = 0; i < N; i++)
            if (vld[i] && vals[i*W +: W] < min_val) min_val = vals[i*W +: W];
    end

endmodule

// File: rtl/cae_pers_multi_ctl.sv
// cae_pers_multi_ctl: dispatch/AEG/CSR front end that launches the phold
// engines, tracks completion or timeout, and reduces engine GVTs to a minimum.
module cae_pers_multi_ctl
    import cae_pers_multi_pkg::*;
#(
    parameter int NUM_ENG = 4,
    parameter int GVT_W   = 14,
    parameter int NUM_AEG = 4
) (
    input  logic                     clk,
    input  logic                     i_reset,
    input  logic                     disp_inst_vld,
    input  logic [4:0]               disp_inst,
    input  logic [17:0]              disp_aeg_idx,
    input  logic                     disp_aeg_rd,
    input  logic                     disp_aeg_wr,
    input  logic [63:0]              disp_aeg_wr_data,
    output logic [17:0]              disp_aeg_cnt,
    output logic [15:0]              disp_exception,
    output logic                     disp_idle,
    output logic                     disp_stall,
    output logic                     disp_rtn_data_vld,
    output logic [63:0]              disp_rtn_data,
    input  logic                     csr_rd_vld,
    input  logic [15:0]              csr_address,
    output logic                     csr_rd_ack,
    output logic [63:0]              csr_rd_data,
    output logic [NUM_ENG-1:0]       eng_rst_n,
    input  logic [NUM_ENG-1:0]       eng_done,
    input  logic [NUM_ENG*GVT_W-1:0] eng_gvt
);

    localparam int AW = $clog2(NUM_AEG);

    state_t                         state_q, state_d;
    logic                           r_start_q, r_start_d, c_start;
    logic [NUM_AEG-1:0][63:0]       aeg_q, aeg_d;
    logic [NUM_ENG-1:0]             mask_q, mask_d, done_seen_q, done_seen_d;
    logic [NUM_ENG-1:0][GVT_W-1:0]  gvt_cap_q, gvt_cap_d;
    logic [63:0]                    cnt_q, cnt_d;
    logic                           timed_out_q, timed_out_d;
    logic [GVT_W-1:0]               min_q, min_d, tree_min;
    logic [3:0]                     exc_q, exc_d;
    logic                           rtn_vld_q, rtn_vld_d, csr_ack_q, csr_ack_d;
    logic [63:0]                    rtn_q, rtn_d, csr_q, csr_d;
    logic [NUM_ENG-1:0]             done_new, mask_aeg;
    logic                           idx_ok, wr_ok, all_done, tmo;
    logic [AW-1:0]                  aidx;

    gvt_min_tree #(.N(NUM_ENG), .W(GVT_W)) u_min (
        .vals    (gvt_cap_q),
        .vld     (done_seen_q),
        .min_val (tree_min)
    );

    assign c_start  = disp_inst_vld && disp_inst == 5'd0;
    assign aidx     = disp_aeg_idx[AW-1:0];
    assign idx_ok   = disp_aeg_idx < 18'(NUM_AEG);
    assign mask_aeg = aeg_q[AEG_MASK][NUM_ENG-1:0];
    assign done_new = eng_done & mask_q & ~done_seen_q;
    // Config registers are frozen while a run is in flight; scratch never is.
    assign wr_ok    = disp_aeg_wr && idx_ok && disp_aeg_idx >= 18'(AEG_MASK) &&
                      (disp_aeg_idx > 18'(AEG_TMO) || state_q == ST_IDLE);

    always_comb begin
        r_start_d   = c_start;
        state_d     = state_q;
        aeg_d       = aeg_q;
        mask_d      = mask_q;
        done_seen_d = done_seen_q;
        gvt_cap_d   = gvt_cap_q;
        cnt_d       = cnt_q;
        timed_out_d = timed_out_q;
        min_d       = min_q;
        all_done    = 1'b0;
        tmo         = 1'b0;
        if (wr_ok) aeg_d[aidx] = disp_aeg_wr_data;
        case (state_q)
            ST_IDLE: if (r_start_q) state_d = ST_LAUNCH;
            ST_LAUNCH: begin
                mask_d      = mask_aeg == '0 ? '1 : mask_aeg;
                done_seen_d = '0;
                gvt_cap_d   = '0;
                cnt_d       = '0;
                timed_out_d = 1'b0;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                for (int i = 0; i < NUM_ENG; i++)
                    if (done_new[i]) gvt_cap_d[i] = eng_gvt[i*GVT_W +: GVT_W];
                done_seen_d = done_seen_q | done_new;
                cnt_d       = &cnt_q ? cnt_q : cnt_q + 64'd1;
                all_done    = done_seen_d == mask_q;
                tmo         = aeg_q[AEG_TMO] != '0 && cnt_q + 64'd1 == aeg_q[AEG_TMO];
                timed_out_d = tmo && !all_done;
                if (all_done || tmo) state_d = ST_REDUCE;
            end
            ST_REDUCE: begin
                min_d   = tree_min;
                state_d = ST_FINISH;
            end
            ST_FINISH: begin
                aeg_d[AEG_RESULT] = {timed_out_q, {(63-GVT_W){1'b0}}, min_q};
                aeg_d[AEG_CYCLES] = cnt_q;
                state_d           = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        exc_d              = '0;
        exc_d[EXC_OPCODE]  = disp_inst_vld && disp_inst != 5'd0;
        exc_d[EXC_IDX]     = (disp_aeg_rd || disp_aeg_wr) && !idx_ok;
        exc_d[EXC_RO]      = disp_aeg_wr && disp_aeg_idx < 18'(AEG_MASK);
        exc_d[EXC_TIMEOUT] = state_q == ST_FINISH && timed_out_q;
        rtn_vld_d          = disp_aeg_rd;
        rtn_d              = disp_aeg_rd && idx_ok ? aeg_q[aidx] : '0;
        csr_ack_d          = csr_rd_vld;
        csr_d              = !csr_rd_vld                ? '0 :
                             csr_address == CSR_STATUS ? {{(61-NUM_ENG){1'b0}}, state_q, done_seen_q} :
                             csr_address == CSR_RESULT ? aeg_q[AEG_RESULT] :
                             csr_address == CSR_CYCLES ? aeg_q[AEG_CYCLES] :
                             csr_address == CSR_MASK   ? {{(64-NUM_ENG){1'b0}}, mask_q} : '0;
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            r_start_q   <= 1'b0;
            aeg_q       <= '0;
            mask_q      <= '0;
            done_seen_q <= '0;
            gvt_cap_q   <= '0;
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
            min_q       <= '0;
            exc_q       <= '0;
            rtn_vld_q   <= 1'b0;
            rtn_q       <= '0;
            csr_ack_q   <= 1'b0;
            csr_q       <= '0;
        end else begin
            state_q     <= state_d;
            r_start_q   <= r_start_d;
            aeg_q       <= aeg_d;
            mask_q      <= mask_d;
            done_seen_q <= done_seen_d;
            gvt_cap_q   <= gvt_cap_d;
            cnt_q       <= cnt_d;
            timed_out_q <= timed_out_d;
            min_q       <= min_d;
            exc_q       <= exc_d;
            rtn_vld_q   <= rtn_vld_d;
            rtn_q       <= rtn_d;
            csr_ack_q   <= csr_ack_d;
            csr_q       <= csr_d;
        end
    end

    assign disp_aeg_cnt      = 18'(NUM_AEG);
    assign disp_exception    = {12'd0, exc_q};
    assign disp_idle         = state_q == ST_IDLE && !r_start_q;
    assign disp_stall        = state_q != ST_IDLE || c_start || r_start_q;
    assign disp_rtn_data_vld = rtn_vld_q;
    assign disp_rtn_data     = rtn_q;
    assign csr_rd_ack        = csr_ack_q;
    assign csr_rd_data       = csr_q;
    assign eng_rst_n         = state_q == ST_RUN ? mask_q : '0;

endmodule

// File: tb/tb_cae_pers_multi_ctl.sv
// tb_cae_pers_multi_ctl: directed checks of AEG access, engine runs,
// timeout, exceptions, CSR reads and mid-run reset.
module tb_cae_pers_multi_ctl;

    localparam int NE = 4;
    localparam int GW = 14;

    logic               clk = 1'b0;
    logic               i_reset = 1'b1;
    logic               disp_inst_vld = 1'b0;
    logic [4:0]         disp_inst = '0;
    logic [17:0]        disp_aeg_idx = '0;
    logic               disp_aeg_rd = 1'b0;
    logic               disp_aeg_wr = 1'b0;
    logic [63:0]        disp_aeg_wr_data = '0;
    logic [17:0]        disp_aeg_cnt;
    logic [15:0]        disp_exception;
    logic               disp_idle, disp_stall, disp_rtn_data_vld;
    logic [63:0]        disp_rtn_data;
    logic               csr_rd_vld = 1'b0;
    logic [15:0]        csr_address = '0;
    logic               csr_rd_ack;
    logic [63:0]        csr_rd_data;
    logic [NE-1:0]      eng_rst_n;
    logic [NE-1:0]      eng_done = '0;
    logic [NE-1:0][GW-1:0] gvt = '0;

    int n_chk = 0;
    int n_fail = 0;
    int dc[NE];

    always #5 clk = ~clk;

    cae_pers_multi_ctl #(.NUM_ENG(NE), .GVT_W(GW), .NUM_AEG(4)) dut (
        .clk               (clk),
        .i_reset           (i_reset),
        .disp_inst_vld     (disp_inst_vld),
        .disp_inst         (disp_inst),
        .disp_aeg_idx      (disp_aeg_idx),
        .disp_aeg_rd       (disp_aeg_rd),
        .disp_aeg_wr       (disp_aeg_wr),
        .disp_aeg_wr_data  (disp_aeg_wr_data),
        .disp_aeg_cnt      (disp_aeg_cnt),
        .disp_exception    (disp_exception),
        .disp_idle         (disp_idle),
        .disp_stall        (disp_stall),
        .disp_rtn_data_vld (disp_rtn_data_vld),
        .disp_rtn_data     (disp_rtn_data),
        .csr_rd_vld        (csr_rd_vld),
        .csr_address       (csr_address),
        .csr_rd_ack        (csr_rd_ack),
        .csr_rd_data       (csr_rd_data),
        .eng_rst_n         (eng_rst_n),
        .eng_done          (eng_done),
        .eng_gvt           (gvt)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic aeg_wr(input logic [17:0] idx, input logic [63:0] d);
        disp_aeg_wr = 1'b1;
        disp_aeg_idx = idx;
        disp_aeg_wr_data = d;
        tick;
        disp_aeg_wr = 1'b0;
    endtask

    task automatic aeg_rd(input string tag, input logic [17:0] idx, input logic [63:0] exp);
        disp_aeg_rd = 1'b1;
        disp_aeg_idx = idx;
        tick;
        disp_aeg_rd = 1'b0;
        check({tag, "_vld"}, 64'(disp_rtn_data_vld), 64'd1);
        check(tag, disp_rtn_data, exp);
    endtask

    task automatic csr_rd(input string tag, input logic [15:0] a, input logic [63:0] exp);
        csr_rd_vld = 1'b1;
        csr_address = a;
        tick;
        csr_rd_vld = 1'b0;
        check({tag, "_ack"}, 64'(csr_rd_ack), 64'd1);
        check(tag, csr_rd_data, exp);
    endtask

    // Issue opcode 0 and walk through r_start and LAUNCH into RUN cycle 1.
    task automatic start_run(input logic [NE-1:0] mask);
        disp_inst_vld = 1'b1;
        disp_inst = 5'd0;
        #1 check("stall_cstart", 64'(disp_stall), 64'd1);
        tick;
        disp_inst_vld = 1'b0;
        check("idle_rstart", 64'(disp_idle), 64'd0);
        tick;
        tick;
        check("rst_n_run", 64'(eng_rst_n), 64'(mask));
        check("stall_run", 64'(disp_stall), 64'd1);
    endtask

    task automatic finish_run(input int ncyc, input logic [NE-1:0] mask, input logic [3:0] exp_exc);
        for (int c = 1; c <= ncyc; c++) begin
            for (int i = 0; i < NE; i++) eng_done[i] = dc[i] != 0 && c >= dc[i];
            if (c == ncyc) check("rst_n_last", 64'(eng_rst_n), 64'(mask));
            tick;
            disp_aeg_wr = 1'b0;
        end
        check("rst_n_reduce", 64'(eng_rst_n), 64'd0);
        eng_done = '0;
        tick;
        tick;
        check("exc_end", 64'(disp_exception), 64'(exp_exc));
        check("idle_end", 64'(disp_idle), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state and empty AEGs
        #2;
        check("rst_idle", 64'(disp_idle), 64'd1);
        check("rst_stall", 64'(disp_stall), 64'd0);
        check("rst_cnt", 64'(disp_aeg_cnt), 64'd4);
        check("rst_rst_n", 64'(eng_rst_n), 64'd0);
        check("rst_exc", 64'(disp_exception), 64'd0);
        check("rst_ack", 64'(csr_rd_ack), 64'd0);
        tick;
        tick;
        i_reset = 1'b0;
        tick;
        for (int i = 0; i < 4; i++) aeg_rd("aeg_init", 18'(i), 64'd0);

        // 2: all four engines, min 12 after 20 cycles
        aeg_wr(18'd2, 64'hF);
        gvt[0] = 14'd37; gvt[1] = 14'd12; gvt[2] = 14'd90; gvt[3] = 14'd12;
        dc[0] = 5; dc[1] = 9; dc[2] = 3; dc[3] = 20;
        start_run(4'hF);
        finish_run(20, 4'hF, 4'h0);
        aeg_rd("t2_aeg0", 18'd0, 64'd12);
        aeg_rd("t2_aeg1", 18'd1, 64'd20);

        // 3: engine 2 never finishes; engine 1 is masked off
        aeg_wr(18'd2, 64'h5);
        aeg_wr(18'd3, 64'd50);
        gvt[0] = 14'd7; gvt[1] = 14'd1; gvt[2] = 14'd0; gvt[3] = 14'd0;
        dc[0] = 4; dc[1] = 2; dc[2] = 0; dc[3] = 0;
        start_run(4'h5);
        finish_run(50, 4'h5, 4'h8);
        aeg_rd("t3_aeg0", 18'd0, 64'h8000_0000_0000_0007);
        aeg_rd("t3_aeg1", 18'd1, 64'd50);
        csr_rd("t3_csr_status", 16'd0, 64'h1);

        // 4: completion and timeout on the same cycle; mask 0 means all
        aeg_wr(18'd2, 64'h0);
        aeg_wr(18'd3, 64'd10);
        gvt[0] = 14'd100; gvt[1] = 14'd200; gvt[2] = 14'd5; gvt[3] = 14'd300;
        for (int i = 0; i < NE; i++) dc[i] = 10;
        start_run(4'hF);
        finish_run(10, 4'hF, 4'h0);
        aeg_rd("t4_aeg0", 18'd0, 64'd5);
        aeg_rd("t4_aeg1", 18'd1, 64'd10);
        csr_rd("t4_csr_result", 16'd1, 64'd5);
        csr_rd("t4_csr_cycles", 16'd2, 64'd10);
        csr_rd("t4_csr_mask", 16'd3, 64'hF);
        csr_rd("t4_csr_status", 16'd0, 64'hF);
        csr_rd("t4_csr_unknown", 16'd7, 64'd0);

        // 5: exceptions, and a config write dropped during RUN
        aeg_wr(18'd0, 64'd123);
        check("t5_exc_ro", 64'(disp_exception), 64'h4);
        aeg_rd("t5_aeg0_kept", 18'd0, 64'd5);
        disp_inst_vld = 1'b1;
        disp_inst = 5'd3;
        tick;
        disp_inst_vld = 1'b0;
        check("t5_exc_op", 64'(disp_exception), 64'h1);
        check("t5_idle_op", 64'(disp_idle), 64'd1);
        aeg_rd("t5_rd_bad", 18'd9, 64'd0);
        check("t5_exc_idx", 64'(disp_exception), 64'h2);
        aeg_wr(18'd3, 64'd6);
        for (int i = 0; i < NE; i++) dc[i] = 0;
        start_run(4'hF);
        disp_aeg_wr = 1'b1;
        disp_aeg_idx = 18'd2;
        disp_aeg_wr_data = 64'h3;
        finish_run(6, 4'hF, 4'h8);
        aeg_rd("t5_aeg2_kept", 18'd2, 64'd0);
        aeg_rd("t5_aeg0", 18'd0, 64'h8000_0000_0000_3FFF);
        aeg_rd("t5_aeg1", 18'd1, 64'd6);

        // 6: async reset mid-RUN, then a normal run
        start_run(4'hF);
        tick;
        tick;
        i_reset = 1'b1;
        #1;
        check("t6_rst_n", 64'(eng_rst_n), 64'd0);
        check("t6_idle", 64'(disp_idle), 64'd1);
        check("t6_stall", 64'(disp_stall), 64'd0);
        tick;
        i_reset = 1'b0;
        tick;
        csr_rd("t6_csr_status", 16'd0, 64'd0);
        aeg_rd("t6_aeg3", 18'd3, 64'd0);
        gvt[0] = 14'd9; gvt[1] = 14'd8; gvt[2] = 14'd7; gvt[3] = 14'd6;
        for (int i = 0; i < NE; i++) dc[i] = 2;
        start_run(4'hF);
        finish_run(2, 4'hF, 4'h0);
        aeg_rd("t6_aeg0", 18'd0, 64'd6);
        aeg_rd("t6_aeg1", 18'd1, 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
